// File: rtl/alpu_pkg.sv
// Shared constants and types for the ALPU issue stage and its register file.
package alpu_pkg;

  localparam int unsigned REG_WIDTH_DEF = 32'd4;
  localparam int unsigned NUM_REGS_DEF  = 32'd4;
  localparam int unsigned OP_W          = 32'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } issue_state_e;

  // Register index width, never narrower than one bit.
  function automatic int unsigned ridx_width(input int unsigned depth);
    if (depth > 32'd1) begin
      return $clog2(depth);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/alpu_issue_stage_if.sv
// Instruction handshake channel from the upstream issuer into the issue stage.
interface alpu_issue_stage_if #(
  parameter int unsigned RIDX_W = 32'd2
);
  import alpu_pkg::*;

  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [OP_W-1:0]   instr_op_i;
  logic [RIDX_W-1:0] instr_rd_i;
  logic [RIDX_W-1:0] instr_rs1_i;
  logic [RIDX_W-1:0] instr_rs2_i;
  logic              instr_usec_i;

  modport master (
    output instr_valid_i, instr_op_i, instr_rd_i, instr_rs1_i, instr_rs2_i, instr_usec_i,
    input  instr_ready_o
  );

  modport slave (
    input  instr_valid_i, instr_op_i, instr_rd_i, instr_rs1_i, instr_rs2_i, instr_usec_i,
    output instr_ready_o
  );

endinterface

// File: rtl/alpu_regfile.sv
// Register file: two combinational read ports, one clocked write port, cleared by reset.
module alpu_regfile
  import alpu_pkg::*;
#(
  parameter  int unsigned REG_WIDTH = REG_WIDTH_DEF,
  parameter  int unsigned NUM_REGS  = NUM_REGS_DEF,
  localparam int unsigned RIDX_W    = ridx_width(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RIDX_W-1:0]    rs1_i,
  input  logic [RIDX_W-1:0]    rs2_i,
  output logic [REG_WIDTH-1:0] rs1_data_o,
  output logic [REG_WIDTH-1:0] rs2_data_o,
  input  logic                 we_i,
  input  logic [RIDX_W-1:0]    waddr_i,
  input  logic [REG_WIDTH-1:0] wdata_i
);

  logic [REG_WIDTH-1:0] rf_q [NUM_REGS];
  logic                 rs1_ok_s;
  logic                 rs2_ok_s;
  logic                 wr_ok_s;

  // Indices past the last entry (non power-of-two depth) read as zero and never write.
  assign rs1_ok_s = (32'(rs1_i) < NUM_REGS);
  assign rs2_ok_s = (32'(rs2_i) < NUM_REGS);
  assign wr_ok_s  = (32'(waddr_i) < NUM_REGS);

  assign rs1_data_o = rs1_ok_s ? rf_q[rs1_i] : {REG_WIDTH{1'b0}};
  assign rs2_data_o = rs2_ok_s ? rf_q[rs2_i] : {REG_WIDTH{1'b0}};

  // Storage update: synchronous clear, otherwise the single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        rf_q[i] <= {REG_WIDTH{1'b0}};
      end
    end else if (we_i && wr_ok_s) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/alpu_issue_stage.sv
// Two-cycle issue stage: reads operands, drives a combinational ALPU, writes the result back.
module alpu_issue_stage
  import alpu_pkg::*;
#(
  parameter  int unsigned REG_WIDTH = REG_WIDTH_DEF,
  parameter  int unsigned NUM_REGS  = NUM_REGS_DEF,
  localparam int unsigned RIDX_W    = ridx_width(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  alpu_issue_stage_if.slave    instr_if,
  output logic [REG_WIDTH-1:0] alpu_a_o,
  output logic [REG_WIDTH-1:0] alpu_b_o,
  output logic [OP_W-1:0]      alpu_instr_o,
  output logic                 alpu_cin_o,
  input  logic [REG_WIDTH-1:0] alpu_out_i,
  input  logic                 alpu_cout_i,
  output logic                 wb_valid_o,
  output logic [RIDX_W-1:0]    wb_rd_o,
  output logic [REG_WIDTH-1:0] wb_data_o,
  output logic                 carry_o
);

  issue_state_e         state_q;
  issue_state_e         state_d;
  logic                 ready_s;
  logic                 hs_s;
  logic                 commit_s;
  logic [REG_WIDTH-1:0] rs1_data_s;
  logic [REG_WIDTH-1:0] rs2_data_s;

  logic [REG_WIDTH-1:0] a_q;
  logic [REG_WIDTH-1:0] b_q;
  logic [OP_W-1:0]      instr_q;
  logic                 cin_q;
  logic [RIDX_W-1:0]    rd_q;
  logic                 carry_q;
  logic                 wb_valid_q;
  logic [RIDX_W-1:0]    wb_rd_q;
  logic [REG_WIDTH-1:0] wb_data_q;

  // Ready depends only on state and reset so upstream can never form a combinational loop.
  assign ready_s  = (state_q == ST_IDLE) && !reset;
  assign hs_s     = instr_if.instr_valid_i && ready_s;
  assign commit_s = (state_q == ST_EXEC) && !reset;

  assign instr_if.instr_ready_o = ready_s;

  alpu_regfile #(
    .REG_WIDTH (REG_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .rs1_i      (instr_if.instr_rs1_i),
    .rs2_i      (instr_if.instr_rs2_i),
    .rs1_data_o (rs1_data_s),
    .rs2_data_o (rs2_data_s),
    .we_i       (commit_s),
    .waddr_i    (rd_q),
    .wdata_i    (alpu_out_i)
  );

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue FSM next state: accept in IDLE, always return after one EXEC cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture: only a handshake edge loads new ALPU inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= {REG_WIDTH{1'b0}};
      b_q     <= {REG_WIDTH{1'b0}};
      instr_q <= {OP_W{1'b0}};
      cin_q   <= 1'b0;
      rd_q    <= {RIDX_W{1'b0}};
    end else if (hs_s) begin
      a_q     <= rs1_data_s;
      b_q     <= rs2_data_s;
      instr_q <= instr_if.instr_op_i;
      cin_q   <= instr_if.instr_usec_i & carry_q;
      rd_q    <= instr_if.instr_rd_i;
    end
  end

  // Writeback: sample the ALPU at the closing EXEC edge; reset during EXEC drops the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= {RIDX_W{1'b0}};
      wb_data_q  <= {REG_WIDTH{1'b0}};
      carry_q    <= 1'b0;
    end else begin
      wb_valid_q <= commit_s;
      if (commit_s) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= alpu_out_i;
        carry_q   <= alpu_cout_i;
      end
    end
  end

  assign alpu_a_o     = a_q;
  assign alpu_b_o     = b_q;
  assign alpu_instr_o = instr_q;
  assign alpu_cin_o   = cin_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign carry_o      = carry_q;

endmodule

// File: tb/tb_alpu_issue_stage.sv
// Self-checking bench for alpu_issue_stage: directed scenarios plus random traffic against a register-level model.
module tb_alpu_issue_stage;
  import alpu_pkg::*;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  alpu_a, alpu_b, alpu_out;
  logic [3:0]    alpu_instr;
  logic          alpu_cin, alpu_cout;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic          carry;

  int errors = 0;
  int checks = 0;
  int m_rf [N];
  int m_carry;
  int stub_s;

  logic [3:0]    n_op;
  logic [RW-1:0] n_rd, n_rs1, n_rs2;
  logic          n_usec;
  bit            ch;

  alpu_issue_stage_if #(.RIDX_W(RW)) ifc ();

  alpu_issue_stage #(.REG_WIDTH(W), .NUM_REGS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_if     (ifc),
    .alpu_a_o     (alpu_a),
    .alpu_b_o     (alpu_b),
    .alpu_instr_o (alpu_instr),
    .alpu_cin_o   (alpu_cin),
    .alpu_out_i   (alpu_out),
    .alpu_cout_i  (alpu_cout),
    .wb_valid_o   (wb_valid),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .carry_o      (carry)
  );

  always #5 clk = ~clk;

  // ALPU stub: op 0 add a+b+cin, op 2 increment a, others xor; result = cout*16 + out.
  function automatic int ref_alpu(input int op, input int a, input int b, input int cin);
    if (op == 0) return a + b + cin;
    else if (op == 2) return a + 1;
    else return a ^ b;
  endfunction

  always_comb stub_s = ref_alpu(int'(alpu_instr), int'(alpu_a), int'(alpu_b), int'(alpu_cin));
  assign alpu_out  = stub_s[3:0];
  assign alpu_cout = stub_s[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [3:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                         input logic [RW-1:0] rs2, input logic usec);
    ifc.instr_valid_i = 1'b1;
    ifc.instr_op_i    = op;
    ifc.instr_rd_i    = rd;
    ifc.instr_rs1_i   = rs1;
    ifc.instr_rs2_i   = rs2;
    ifc.instr_usec_i  = usec;
  endtask

  task automatic present_rand();
    present(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
  endtask

  // One presented instruction through handshake and writeback; chain presents n_* during EXEC.
  task automatic run_one(input bit chain);
    int wait_cnt, ea, eb, ec, op, s, rd;
    wait_cnt = 0;
    while (ifc.instr_ready_o !== 1'b1 && wait_cnt < 8) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("ready_idle", 32'(ifc.instr_ready_o), 32'd1);
    ea = m_rf[ifc.instr_rs1_i];
    eb = m_rf[ifc.instr_rs2_i];
    ec = ifc.instr_usec_i ? m_carry : 0;
    op = int'(ifc.instr_op_i);
    rd = int'(ifc.instr_rd_i);
    s  = ref_alpu(op, ea, eb, ec);
    @(posedge clk); #1;
    check("alpu_a", 32'(alpu_a), 32'(ea));
    check("alpu_b", 32'(alpu_b), 32'(eb));
    check("alpu_instr", 32'(alpu_instr), 32'(op));
    check("alpu_cin", 32'(alpu_cin), 32'(ec));
    check("ready_exec", 32'(ifc.instr_ready_o), 32'd0);
    check("wb_quiet_exec", 32'(wb_valid), 32'd0);
    if (chain) present(n_op, n_rd, n_rs1, n_rs2, n_usec);
    else ifc.instr_valid_i = 1'b0;
    @(posedge clk); #1;
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("wb_rd", 32'(wb_rd), 32'(rd));
    check("wb_data", 32'(wb_data), 32'(s % 16));
    check("carry", 32'(carry), 32'(s / 16));
    check("ready_after", 32'(ifc.instr_ready_o), 32'd1);
    m_rf[rd] = s % 16;
    m_carry  = s / 16;
    if (!chain) begin
      @(posedge clk); #1;
      check("wb_pulse_end", 32'(wb_valid), 32'd0);
      check("wb_data_hold", 32'(wb_data), 32'(s % 16));
      check("alpu_a_hold", 32'(alpu_a), 32'(ea));
    end
  endtask

  // Build a register value from zero by doubling and incrementing, MSB first.
  task automatic setr(input logic [RW-1:0] r, input int val);
    present(4'h5, r, r, r, 1'b0);
    run_one(1'b0);
    for (int b = W - 1; b >= 0; b--) begin
      present(4'h0, r, r, r, 1'b0);
      run_one(1'b0);
      if (val[b]) begin
        present(4'h2, r, r, r, 1'b0);
        run_one(1'b0);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) m_rf[i] = 0;
    m_carry = 0;
    reset = 1'b1;
    present(4'h0, 2'd1, 2'd1, 2'd1, 1'b1);

    // Reset state, with valid held high to show nothing is accepted.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ready", 32'(ifc.instr_ready_o), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_alpu_a", 32'(alpu_a), 32'd0);
    check("rst_alpu_cin", 32'(alpu_cin), 32'd0);
    ifc.instr_valid_i = 1'b0;
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(ifc.instr_ready_o), 32'd1);

    // r1 = 3, then r2 = r1 + r1.
    setr(2'd1, 3);
    present(4'h0, 2'd2, 2'd1, 2'd1, 1'b0);
    run_one(1'b0);
    check("add_data", 32'(wb_data), 32'h6);
    check("add_rd", 32'(wb_rd), 32'd2);
    check("add_carry", 32'(carry), 32'd0);

    // Carry chain into a carry-in consumer.
    setr(2'd0, 0);
    setr(2'd1, 15);
    setr(2'd2, 1);
    present(4'h0, 2'd3, 2'd1, 2'd2, 1'b0);
    run_one(1'b0);
    check("chain1_data", 32'(wb_data), 32'h0);
    check("chain1_carry", 32'(carry), 32'd1);
    present(4'h0, 2'd0, 2'd0, 2'd0, 1'b1);
    run_one(1'b0);
    check("chain2_cin", 32'(alpu_cin), 32'd1);
    check("chain2_data", 32'(wb_data), 32'h1);
    check("chain2_carry", 32'(carry), 32'd0);

    // Back-to-back RAW with valid held high through EXEC.
    present(4'h0, 2'd1, 2'd1, 2'd1, 1'b0);
    n_op = 4'h0; n_rd = 2'd2; n_rs1 = 2'd1; n_rs2 = 2'd1; n_usec = 1'b1;
    run_one(1'b1);
    run_one(1'b0);
    check("raw_data", 32'(wb_data), 32'hD);
    check("raw_carry", 32'(carry), 32'd1);

    // All three indices equal.
    setr(2'd1, 5);
    present(4'h0, 2'd1, 2'd1, 2'd1, 1'b0);
    run_one(1'b0);
    check("same_idx_data", 32'(wb_data), 32'hA);

    // Random traffic, chained or spaced.
    present_rand();
    for (int i = 0; i < 40; i++) begin
      ch = (i < 39) && ($urandom_range(0, 1) == 1);
      if (ch) begin
        n_op = 4'($urandom_range(0, 15)); n_rd = 2'($urandom_range(0, 3));
        n_rs1 = 2'($urandom_range(0, 3)); n_rs2 = 2'($urandom_range(0, 3));
        n_usec = 1'($urandom_range(0, 1));
      end
      run_one(ch);
      if (!ch && i < 39) present_rand();
    end

    // Reset raised during EXEC aborts the instruction.
    setr(2'd1, 15);
    present(4'h0, 2'd2, 2'd1, 2'd1, 1'b0);
    run_one(1'b0);
    check("pre_abort_carry", 32'(carry), 32'd1);
    present(4'h0, 2'd3, 2'd1, 2'd1, 1'b1);
    #1;
    check("abort_ready", 32'(ifc.instr_ready_o), 32'd1);
    @(posedge clk); #1;
    check("abort_exec_a", 32'(alpu_a), 32'hF);
    ifc.instr_valid_i = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_no_wb", 32'(wb_valid), 32'd0);
    check("abort_ready_rst", 32'(ifc.instr_ready_o), 32'd0);
    check("abort_carry", 32'(carry), 32'd0);
    check("abort_wb_data", 32'(wb_data), 32'd0);
    @(posedge clk); #1;
    check("abort_no_wb2", 32'(wb_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("abort_ready_rel", 32'(ifc.instr_ready_o), 32'd1);
    for (int i = 0; i < N; i++) m_rf[i] = 0;
    m_carry = 0;
    for (int r = 0; r < N; r++) begin
      present(4'h0, 2'(r), 2'(r), 2'(r), 1'b1);
      run_one(1'b0);
    end
    check("post_rst_carry", 32'(carry), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alpu_issue_stage.md
ALPU_ISSUE_STAGE -- requirements
Module: alpu_issue_stage

Interface
REQ-001 Parameter REG_WIDTH, default 4: datapath width, equal to the ALPU operand width.
REQ-002 Parameter NUM_REGS, default 4: register-file depth; index width RIDX_W = clog2(NUM_REGS), minimum 1.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instr_valid_i  in  1  upstream instruction valid.
REQ-006 instr_ready_o  out  1  block can accept an instruction this cycle.
REQ-007 instr_op_i  in  4  ALPU opcode, passed through unchanged.
REQ-008 instr_rd_i / instr_rs1_i / instr_rs2_i  in  RIDX_W each  destination and source register indices.
REQ-009 instr_usec_i  in  1  1: cin = carry flag; 0: cin = 0.
REQ-010 alpu_a_o / alpu_b_o  out  REG_WIDTH  operands to the ALPU a_i / b_i.
REQ-011 alpu_instr_o  out  4  to ALPU instr_i; alpu_cin_o  out  1  to ALPU cin_i.
REQ-012 alpu_out_i  in  REG_WIDTH  ALPU out_o; alpu_cout_i  in  1  ALPU cout_o.
REQ-013 wb_valid_o  out  1; wb_rd_o  out  RIDX_W; wb_data_o  out  REG_WIDTH  one-cycle writeback report.
REQ-014 carry_o  out  1  current carry flag.

Function
REQ-015 FSM states: IDLE and EXEC; IDLE -> EXEC on handshake (instr_valid_i & instr_ready_o); EXEC -> IDLE unconditionally after one cycle.
REQ-016 instr_ready_o SHALL be 1 only in IDLE with reset low; it is a function of state only, never of instr_valid_i.
REQ-017 On handshake, the block SHALL register rf[rs1] into alpu_a_o, rf[rs2] into alpu_b_o, op into alpu_instr_o, usec ? carry : 0 into alpu_cin_o, and latch rd.
REQ-018 The ALPU is combinational; in EXEC the block SHALL sample alpu_out_i and alpu_cout_i at the closing edge.
REQ-019 At that edge the block SHALL write rf[rd] = alpu_out_i and carry = alpu_cout_i, and register wb_valid_o=1, wb_rd_o=rd, wb_data_o=alpu_out_i.
REQ-020 wb_valid_o SHALL be high for exactly one cycle, the IDLE cycle after EXEC; wb_rd_o and wb_data_o hold their last values otherwise.
REQ-021 Latency: handshake at edge N, writeback visible at edge N+2 and wb_valid_o high in cycle N+2. Throughput: one instruction per 2 cycles.
REQ-022 RAW: an instruction accepted in the IDLE cycle right after EXEC SHALL read the just-written rf[rd] and carry; no bypass is needed because the write lands first.
REQ-023 rd == rs1, rd == rs2, or rs1 == rs2 SHALL behave as plain reads of the pre-instruction values.
REQ-024 alpu_a_o, alpu_b_o, alpu_instr_o and alpu_cin_o SHALL hold their values outside handshake edges; no other update path exists.
REQ-025 The block SHALL ignore instr_valid_i in EXEC; upstream holds the instruction until instr_ready_o.
REQ-026 Arithmetic is performed only by the ALPU; no width extension; carry SHALL be updated only by REQ-019.

Reset
REQ-027 While reset is high at an edge: state=IDLE, all rf entries=0, carry=0, alpu_* outputs=0, wb_valid_o=0, wb_rd_o=0, wb_data_o=0.
REQ-028 instr_ready_o SHALL be 0 in every cycle where reset is high.
REQ-029 Reset asserted during EXEC SHALL abort the instruction: no rf, carry or wb update.

Structure
REQ-030 Shared package alpu_pkg SHALL hold the REG_WIDTH and NUM_REGS defaults, the opcode width constant (4), and the issue-state enum.
REQ-031 Register file SHALL be the sub-module alpu_regfile: two combinational read ports, one synchronous write port, synchronous reset clear.
REQ-032 Top-level RTL: FSM, operand registers and writeback registers only.

Verification (bench ALPU stub: op 4'h0 = add, out = a+b+cin mod 16, cout = carry out)
REQ-033 Reset, then load r1=3 via prior adds: issue add rd=2, rs1=1, rs2=1, usec=0 -> wb_valid_o in cycle N+2, wb_rd_o=2, wb_data_o=6, carry_o=0.
REQ-034 Carry chain: r1=0xF, r2=0x1; add rd=3 (1+2, usec=0) -> data 0x0, carry 1; then add rd=0 (0+0, usec=1) -> alpu_cin_o=1, data 0x1, carry 0.
REQ-035 Back-to-back RAW with instr_valid_i held high: instr_ready_o toggles 1,0,1,0; second instruction reads the value written by the first.
REQ-036 Valid asserted during EXEC -> not accepted; accepted at the next IDLE; exactly one wb_valid_o pulse per instruction.
REQ-037 Reset raised in EXEC -> no wb_valid_o; rf all 0; carry 0; instr_ready_o 0 during reset, then 1.
REQ-038 rd == rs1 == rs2 = 1 with r1=5 -> wb_data_o = 0xA.
